// File: rtl/mem_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sram_bridge
//  Description : Bridges one arbitrated request at a time onto a 64-bit
//                synchronous single-port SRAM.
//                Flow: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE.
//                Byte/half/word/dword accesses are lane-aligned on the way
//                in. Read data is right-justified and zero-extended on the
//                way out.
//  Parameters  : WAIT_STATES (0..15) - idle cycles inserted before each access
//                ADDR_W              - SRAM word-address width (64-bit words)
//  Ports       : clk, rst_n (async assert, active low)
//                req_valid, PADDR, HWRITE, PDATA, HSIZE   - request side
//                busy, resp_valid, resp_rdata, resp_err   - response side
//                mem_en, mem_we, mem_addr, mem_be,
//                mem_wdata, mem_rdata                     - SRAM side
//  Options     : `define MEM_BRIDGE_MISALIGN_ERR_EN turns misaligned requests
//                into error responses that never touch the SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_bridge #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [63:0]       PADDR,
    input  logic              HWRITE,
    input  logic [63:0]       PDATA,
    input  logic [1:0]        HSIZE,
    output logic              busy,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [ADDR_W+2:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [63:0]       data_q,  data_d;
    logic [1:0]        size_q,  size_d;

    // Only the byte offset and the word address are needed from PADDR.
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[63:ADDR_W+3];

`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
    logic err_q, err_d;
    logic w_misalign;

    // An access is aligned when the offset bits below its size are zero.
    always_comb begin
        w_misalign = 1'b0;
        case (HSIZE)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = PADDR[0];
            2'd2:    w_misalign = |PADDR[1:0];
            default: w_misalign = |PADDR[2:0];
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            size_q  <= '0;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            data_q  <= data_d;
            size_q  <= size_d;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        data_d  = data_q;
        size_d  = size_q;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = PADDR[ADDR_W+2:0];
                    we_d   = HWRITE;
                    data_d = PDATA;
                    size_d = HSIZE;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
                    err_d  = w_misalign;
                    if (w_misalign) begin
                        state_d = ST_RESP;
                    end else
`endif
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                // Counter holds the wait cycles still to spend including this one.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane alignment
    // ------------------------------------------------------------------
    logic [7:0]  w_be_base;
    logic [63:0] w_rmask;
    logic [63:0] w_rshift;
    logic        w_rd_ok;

    always_comb begin
        w_be_base = 8'h00;
        w_rmask   = '0;
        case (size_q)
            2'd0:    begin w_be_base = 8'h01; w_rmask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin w_be_base = 8'h03; w_rmask = 64'h0000_0000_0000_FFFF; end
            2'd2:    begin w_be_base = 8'h0F; w_rmask = 64'h0000_0000_FFFF_FFFF; end
            default: begin w_be_base = 8'hFF; w_rmask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    // SRAM data arrives during RESP, one cycle after the ACCESS strobe.
    assign w_rshift = mem_rdata >> {addr_q[2:0], 3'b000};

`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
    assign w_rd_ok  = (state_q == ST_RESP) && !we_q && !err_q;
    assign resp_err = (state_q == ST_RESP) && err_q;
`else
    assign w_rd_ok  = (state_q == ST_RESP) && !we_q;
    assign resp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = w_rd_ok ? (w_rshift & w_rmask) : 64'd0;

    assign mem_en     = (state_q == ST_ACCESS);
    assign mem_we     = (state_q == ST_ACCESS) && we_q;
    // An 8-bit shift drops lanes that would spill past the dword on misaligned accesses.
    assign mem_be     = (state_q == ST_ACCESS) ? (w_be_base << addr_q[2:0]) : 8'h00;
    assign mem_addr   = addr_q[ADDR_W+2:3];
    assign mem_wdata  = data_q << {addr_q[2:0], 3'b000};

endmodule
`default_nettype wire
